// File: rtl/decode_regfile_pkg.sv
// Shared decode/execute definitions: opcodes, instruction field positions,
// register-file geometry and the decode output record.
package decode_regfile_pkg;

  localparam int RF_DEPTH = 16;
  localparam int RF_WIDTH = 8;
  localparam int RF_AW    = $clog2(RF_DEPTH);
  localparam int NUM_RD   = 2;

  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int DST_HI  = 11;
  localparam int DST_LO  = 8;
  localparam int S1_HI   = 7;
  localparam int S1_LO   = 4;
  localparam int S2_HI   = 3;
  localparam int S2_LO   = 0;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_ADD    = 4'b0001,
    OP_SUB    = 4'b0010,
    OP_LSHIFT = 4'b0100,
    OP_RSHIFT = 4'b1000
  } opcode_e;

  typedef struct packed {
    logic [3:0]          op;
    logic [RF_WIDTH-1:0] s1data;
    logic [RF_WIDTH-1:0] s2data;
    logic [RF_AW-1:0]    dest;
  } dec_out_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LSHIFT) || (op == OP_RSHIFT);
  endfunction

  // Only ADD/SUB read src2; shifts take their amount from elsewhere.
  function automatic logic uses_src2(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/regfile_16x8.sv
// 16x8 register file: one write port, NUM_RD read ports with write-through bypass.
module regfile_16x8
  import decode_regfile_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_write_en,
  input  logic [RF_AW-1:0]                 i_write_add,
  input  logic [RF_WIDTH-1:0]              i_write_data,
  input  logic [NUM_RD-1:0][RF_AW-1:0]     i_read_add,
  output logic [NUM_RD-1:0][RF_WIDTH-1:0]  o_read_data
);

  logic [RF_DEPTH-1:0][RF_WIDTH-1:0] r_mem;
  logic                              w_we;

  // Writes presented while reset is held must not leak through the bypass.
  assign w_we = i_write_en & i_reset;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)  r_mem <= '0;
    else if (w_we) r_mem[i_write_add] <= i_write_data;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign o_read_data[p] = (w_we && (i_write_add == i_read_add[p])) ? i_write_data
                                                                      : r_mem[i_read_add[p]];
  end

endmodule

// File: rtl/decode_regfile.sv
// Decode stage: operand fetch, single-entry RAW hazard stall, illegal-opcode
// squash and the one-cycle pipeline register toward execute.
module decode_regfile
  import decode_regfile_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [INSTR_W-1:0]  i_instr,
  input  logic                i_instr_valid,
  output logic                o_instr_ready,
  input  logic                i_write_en,
  input  logic [RF_AW-1:0]    i_write_add,
  input  logic [RF_WIDTH-1:0] i_write_data,
  output logic [3:0]          o_opcode,
  output logic [RF_WIDTH-1:0] o_srcdata1,
  output logic [RF_WIDTH-1:0] o_srcdata2,
  output logic [RF_AW-1:0]    o_destadd,
  output logic                o_illegal
);

  logic [3:0]                      w_op;
  logic [RF_AW-1:0]                w_dst, w_s1, w_s2;
  logic [NUM_RD-1:0][RF_AW-1:0]    w_radd;
  logic [NUM_RD-1:0][RF_WIDTH-1:0] w_rdata;
  logic                            w_hazard, w_accept, w_legal, w_load;
  dec_out_t                        w_next, r_out;
  logic                            r_ill, r_infl;
  logic [RF_AW-1:0]                r_infl_dst;

  assign w_op  = i_instr[OPC_HI:OPC_LO];
  assign w_dst = i_instr[DST_HI:DST_LO];
  assign w_s1  = i_instr[S1_HI:S1_LO];
  assign w_s2  = i_instr[S2_HI:S2_LO];
  assign w_radd = {w_s2, w_s1};

  regfile_16x8 u_rf (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_write_en   (i_write_en),
    .i_write_add  (i_write_add),
    .i_write_data (i_write_data),
    .i_read_add   (w_radd),
    .o_read_data  (w_rdata)
  );

  assign w_hazard = r_infl && ((w_s1 == r_infl_dst) || (uses_src2(w_op) && (w_s2 == r_infl_dst)));
  assign o_instr_ready = ~w_hazard;
  assign w_accept = i_instr_valid & ~w_hazard;
  assign w_legal  = is_legal(w_op);
  assign w_load   = w_accept & w_legal;

  always_comb begin
    w_next = '0;
    if (w_load) begin
      w_next.op     = w_op;
      w_next.s1data = w_rdata[0];
      w_next.s2data = uses_src2(w_op) ? w_rdata[1] : '0;
      w_next.dest   = w_dst;
    end
  end

  // Anything other than a legal accept loads a bubble and retires in-flight,
  // which is what bounds a stall to a single cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out      <= '0;
      r_ill      <= 1'b0;
      r_infl     <= 1'b0;
      r_infl_dst <= '0;
    end else begin
      r_out      <= w_next;
      r_ill      <= w_accept & ~w_legal;
      r_infl     <= w_load;
      r_infl_dst <= w_load ? w_dst : '0;
    end
  end

  assign o_opcode   = r_out.op;
  assign o_srcdata1 = r_out.s1data;
  assign o_srcdata2 = r_out.s2data;
  assign o_destadd  = r_out.dest;
  assign o_illegal  = r_ill;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed table-driven bench for decode_regfile plus hand sequences for
// back-to-back issue and reset during a stall.
module tb_decode_regfile;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_instr;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic        i_write_en;
  logic [3:0]  i_write_add;
  logic [7:0]  i_write_data;
  logic [3:0]  o_opcode;
  logic [7:0]  o_srcdata1, o_srcdata2;
  logic [3:0]  o_destadd;
  logic        o_illegal;

  int checks = 0;
  int errors = 0;

  decode_regfile dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
    .o_instr_ready(o_instr_ready), .i_write_en(i_write_en), .i_write_add(i_write_add),
    .i_write_data(i_write_data), .o_opcode(o_opcode), .o_srcdata1(o_srcdata1),
    .o_srcdata2(o_srcdata2), .o_destadd(o_destadd), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] instr;
    logic        vld;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        rdy;
    logic [3:0]  op;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [3:0]  dst;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] op, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [3:0] dst, input logic ill);
    chk({nm, ".op"},  {28'd0, o_opcode},   {28'd0, op});
    chk({nm, ".s1"},  {24'd0, o_srcdata1}, {24'd0, s1});
    chk({nm, ".s2"},  {24'd0, o_srcdata2}, {24'd0, s2});
    chk({nm, ".dst"}, {28'd0, o_destadd},  {28'd0, dst});
    chk({nm, ".ill"}, {31'd0, o_illegal},  {31'd0, ill});
  endtask

  // Drive at negedge, sample ready before the edge, outputs just after it.
  task automatic step(input logic [15:0] instr, input logic vld, input logic we,
                      input logic [3:0] wa, input logic [7:0] wd, output logic rdy);
    @(negedge i_clk);
    i_instr = instr; i_instr_valid = vld;
    i_write_en = we; i_write_add = wa; i_write_data = wd;
    #1 rdy = o_instr_ready;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic rdy;
    //          instr    v  we wa    wd     rdy op    s1     s2     dst   ill
    vt[0]  = '{16'h0000, 0, 1, 4'h3, 8'h05, 1, 4'h0, 8'h00, 8'h00, 4'h0, 0};
    vt[1]  = '{16'h0000, 0, 1, 4'h4, 8'h02, 1, 4'h0, 8'h00, 8'h00, 4'h0, 0};
    vt[2]  = '{16'h1534, 1, 0, 4'h0, 8'h00, 1, 4'h1, 8'h05, 8'h02, 4'h5, 0};
    vt[3]  = '{16'h0000, 0, 1, 4'h1, 8'h11, 1, 4'h0, 8'h00, 8'h00, 4'h0, 0};
    vt[4]  = '{16'h1612, 1, 1, 4'h2, 8'h22, 1, 4'h1, 8'h11, 8'h22, 4'h6, 0};
    vt[5]  = '{16'h2761, 1, 1, 4'h6, 8'h66, 0, 4'h0, 8'h00, 8'h00, 4'h0, 0};
    vt[6]  = '{16'h2761, 1, 0, 4'h0, 8'h00, 1, 4'h2, 8'h66, 8'h11, 4'h7, 0};
    vt[7]  = '{16'h4893, 1, 1, 4'h9, 8'hA5, 1, 4'h4, 8'hA5, 8'h00, 4'h8, 0};
    vt[8]  = '{16'h8A38, 1, 0, 4'h0, 8'h00, 1, 4'h8, 8'h05, 8'h00, 4'hA, 0};
    vt[9]  = '{16'h7B30, 1, 0, 4'h0, 8'h00, 1, 4'h0, 8'h00, 8'h00, 4'h0, 1};
    vt[10] = '{16'h1CB3, 1, 0, 4'h0, 8'h00, 1, 4'h1, 8'h00, 8'h05, 4'hC, 0};
    vt[11] = '{16'h0000, 0, 0, 4'h0, 8'h00, 1, 4'h0, 8'h00, 8'h00, 4'h0, 0};
    vt[12] = '{16'h1D34, 1, 0, 4'h0, 8'h00, 1, 4'h1, 8'h05, 8'h02, 4'hD, 0};
    vt[13] = '{16'h1E1D, 1, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 8'h00, 4'h0, 0};
    vt[14] = '{16'h1E1D, 1, 0, 4'h0, 8'h00, 1, 4'h1, 8'h11, 8'h00, 4'hE, 0};

    // Reset state, with a valid instruction and a write presented.
    i_reset = 1'b0; i_instr = 16'h1534; i_instr_valid = 1'b1;
    i_write_en = 1'b1; i_write_add = 4'h3; i_write_data = 8'hFF;
    #12;
    chk_out("reset", 4'h0, 8'h00, 8'h00, 4'h0, 1'b0);
    chk("reset.rdy", {31'd0, o_instr_ready}, 32'd1);
    @(negedge i_clk);
    i_instr_valid = 1'b0; i_write_en = 1'b0;
    i_reset = 1'b1;

    for (int k = 0; k < NV; k++) begin
      step(vt[k].instr, vt[k].vld, vt[k].we, vt[k].wa, vt[k].wd, rdy);
      chk($sformatf("v%0d.rdy", k), {31'd0, rdy}, {31'd0, vt[k].rdy});
      chk_out($sformatf("v%0d", k), vt[k].op, vt[k].s1, vt[k].s2, vt[k].dst, vt[k].ill);
    end

    // Back-to-back independent ADDs over R0..R7.
    for (int r = 0; r < 8; r++) step(16'h0000, 0, 1, 4'(r), 8'h30 + 8'(r), rdy);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] s1, s2, d;
      s1 = 4'(i); s2 = 4'((i + 1) % 8); d = 4'(8 + i);
      step({4'h1, d, s1, s2}, 1, 0, 4'h0, 8'h00, rdy);
      chk($sformatf("b2b%0d.rdy", i), {31'd0, rdy}, 32'd1);
      chk_out($sformatf("b2b%0d", i), 4'h1, 8'h30 + 8'(s1), 8'h30 + 8'(s2), d, 1'b0);
    end

    // Reset asserted while a dependent SUB is stalled.
    step(16'h1512, 1, 0, 4'h0, 8'h00, rdy);
    chk_out("pre_rst", 4'h1, 8'h31, 8'h32, 4'h5, 1'b0);
    @(negedge i_clk);
    i_instr = 16'h2650; i_instr_valid = 1'b1;
    #1 chk("stall.rdy", {31'd0, o_instr_ready}, 32'd0);
    #1 i_reset = 1'b0;
    #1;
    chk_out("async_rst", 4'h0, 8'h00, 8'h00, 4'h0, 1'b0);
    chk("async_rst.rdy", {31'd0, o_instr_ready}, 32'd1);
    @(posedge i_clk); #1;
    chk_out("in_rst", 4'h0, 8'h00, 8'h00, 4'h0, 1'b0);
    @(negedge i_clk);
    i_instr_valid = 1'b0;
    i_reset = 1'b1;
    step(16'h1134, 1, 0, 4'h0, 8'h00, rdy);
    chk("post_rst.rdy", {31'd0, rdy}, 32'd1);
    chk_out("post_rst", 4'h1, 8'h00, 8'h00, 4'h1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
